// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM encoding and result codes for the bit-serial comparator
//   ST_*      : 2-bit controller state encoding (2'd3 is illegal, recovers to IDLE)
//   cmp_res_e : encoded compare result for consumers that want a single field
package cmp_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {RES_NONE, RES_EQ, RES_GT, RES_LT} cmp_res_e;
    function automatic cmp_res_e res_code(input logic eq, input logic gt, input logic lt);
        return eq ? RES_EQ : gt ? RES_GT : lt ? RES_LT : RES_NONE;
    endfunction
endpackage

// File: rtl/serial_cmp_ctrl_bit_eq_cell.sv
// bit_eq_cell: combinational 1-bit equality cell
//   x, y : operand bits
//   z    : 1 when x == y
module bit_eq_cell (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = (~x & ~y) | (x & y);
endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: MSB-first bit-serial eq/gt/lt comparator built on one equality cell
//   clk, rst      : clock, asynchronous active-high reset
//   start, a, b   : compare request and operands, sampled when accepted in IDLE
//   busy, done    : busy in SCAN/DONE, one-cycle done pulse when results are valid
//   eq, gt, lt    : unsigned compare result, held until the next accepted start
//   cycles        : SCAN cycles spent by the last operation
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic             mis_q, mis_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic             busy_q, done_q;
    logic             z;
    logic             first_mis;
    bit_eq_cell u_cell (
        .x(a_q[idx_q]),
        .y(b_q[idx_q]),
        .z(z)
    );
    // only the most significant mismatch decides gt/lt
    assign first_mis = !z && !mis_q;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cycles_d = cycles_q;
        mis_d    = mis_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                a_d      = a;
                b_d      = b;
                idx_d    = IW'(WIDTH - 1);
                cycles_d = '0;
                mis_d    = 1'b0;
                eq_d     = 1'b0;
                gt_d     = 1'b0;
                lt_d     = 1'b0;
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                cycles_d = cycles_q + CW'(1);
                if (first_mis) begin
                    gt_d  = a_q[idx_q];
                    lt_d  = !a_q[idx_q];
                    mis_d = 1'b1;
                end
                if (first_mis && EARLY_EXIT) state_d = ST_DONE;
                else if (idx_q == '0) begin
                    eq_d    = !mis_d;
                    state_d = ST_DONE;
                end else idx_d = idx_q - IW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cycles_q <= '0;
            mis_q    <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cycles_q <= cycles_d;
            mis_q    <= mis_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            busy_q   <= (state_d == ST_SCAN) || (state_d == ST_DONE);
            done_q   <= (state_d == ST_DONE);
        end
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign eq     = eq_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl: scoreboard bench for serial_cmp_ctrl with early-exit and full-scan instances
module tb_serial_cmp_ctrl;
    localparam int W = 8;
    typedef struct {
        int eq;
        int gt;
        int lt;
        int cycles;
        int dc;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0, start1 = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy0, done0, eq0, gt0, lt0;
    logic         busy1, done1, eq1, gt1, lt1;
    logic [3:0]   cyc0, cyc1;
    exp_t         q0[$], q1[$];
    exp_t         m0, m1;
    int           checks = 0, errors = 0, cyc = 0;
    int           acc;

    serial_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0), .cycles(cyc0)
    );
    serial_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1), .cycles(cyc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // reference: plain unsigned compare; early exit stops at the highest differing bit
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input bit ee, input int acc_c);
        exp_t e;
        int x;
        x = int'(av ^ bv);
        e.eq = int'(av == bv);
        e.gt = int'(av > bv);
        e.lt = int'(av < bv);
        e.cycles = (ee && x != 0) ? W + 1 - $clog2(x + 1) : W;
        e.dc = acc_c + e.cycles;
        return e;
    endfunction

    always @(negedge clk) if (!rst) begin
        if (done0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_done unexpected pulse at cycle %0d", cyc);
            end else begin
                m0 = q0.pop_front();
                chk("dut0_eq", int'(eq0), m0.eq);
                chk("dut0_gt", int'(gt0), m0.gt);
                chk("dut0_lt", int'(lt0), m0.lt);
                chk("dut0_cycles", int'(cyc0), m0.cycles);
                chk("dut0_done_cycle", cyc, m0.dc);
                chk("dut0_busy_at_done", int'(busy0), 1);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_done unexpected pulse at cycle %0d", cyc);
            end else begin
                m1 = q1.pop_front();
                chk("dut1_eq", int'(eq1), m1.eq);
                chk("dut1_gt", int'(gt1), m1.gt);
                chk("dut1_lt", int'(lt1), m1.lt);
                chk("dut1_cycles", int'(cyc1), m1.cycles);
                chk("dut1_done_cycle", cyc, m1.dc);
                chk("dut1_busy_at_done", int'(busy1), 1);
            end
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while ((d ? busy1 : busy0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", n, 0);
    endtask

    task automatic op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv, input bit push, output int acc_o);
        wait_idle(d);
        a = av;
        b = bv;
        if (d != 0) start1 = 1'b1;
        else start0 = 1'b1;
        @(posedge clk);
        #1;
        acc_o = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
        if (push) begin
            if (d != 0) q1.push_back(model(av, bv, 1'b0, acc_o));
            else q0.push_back(model(av, bv, 1'b1, acc_o));
        end
        chk("busy_after_accept", int'(d ? busy1 : busy0), 1);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_eq0", int'(eq0), 0);
        chk("rst_gt0", int'(gt0), 0);
        chk("rst_lt0", int'(lt0), 0);
        chk("rst_cycles0", int'(cyc0), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_eq1", int'(eq1), 0);
        chk("rst_cycles1", int'(cyc1), 0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 8'hA5, 8'hA5, 1'b1, acc);
        op(0, 8'h80, 8'h7F, 1'b1, acc);
        op(0, 8'h12, 8'h13, 1'b1, acc);
        op(1, 8'h80, 8'h00, 1'b1, acc);
        op(1, 8'h81, 8'h40, 1'b1, acc);
        wait_idle(0);
        a = 8'hF0;
        b = 8'h0F;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        q0.push_back(model(8'hF0, 8'h0F, 1'b1, acc));
        repeat (2) @(posedge clk);
        #1;
        a = 8'h00;
        b = 8'hFF;
        @(posedge clk);
        #1;
        q0.push_back(model(8'h00, 8'hFF, 1'b1, acc + 3));
        start0 = 1'b0;
        wait_idle(0);
        wait_idle(1);
        op(0, 8'h3C, 8'h3C, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cycles", int'(cyc0), 3);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy0), 0);
        chk("async_rst_done", int'(done0), 0);
        chk("async_rst_eq", int'(eq0), 0);
        chk("async_rst_gt", int'(gt0), 0);
        chk("async_rst_lt", int'(lt0), 0);
        chk("async_rst_cycles", int'(cyc0), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        op(0, 8'h01, 8'h02, 1'b1, acc);
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            op(i % 2, ra, rb, 1'b1, acc);
        end
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_pending", q0.size() + q1.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
